// File: rtl/gbus_core_rx_if.sv
// Global-bus snoop interface: broadcast address, valid strobe and data.
// master drives the bus (arbiter side), slave observes it (receivers).
interface gbus_core_rx_if #(
  parameter int DW = 32
);
  logic [18:0]   gbus_addr;
  logic          gbus_wen;
  logic [DW-1:0] gbus_wdata;

  modport master (
    output gbus_addr,
    output gbus_wen,
    output gbus_wdata
  );

  modport slave (
    input gbus_addr,
    input gbus_wen,
    input gbus_wdata
  );
endinterface

// File: rtl/gbus_core_rx.sv
// Per-core global-bus receiver: filters bus words by core id, buffers
// them in a FIFO, drains into the core SRAM port and tracks completion.
// Ports: clk, rst_n (sync, active-high), bus (gbus snoop, slave),
//   cfg_start/cfg_len (transfer setup), core_sram_busy (drain stall),
//   sram_wen/bank/addr/wdata (registered SRAM write),
//   rx_busy, rx_done (pulse), fifo_ovf (sticky drop flag).
module gbus_core_rx #(
  parameter logic [3:0] CORE_INDEX      = 4'd0,
  parameter int         GBUS_DATA_WIDTH = 32,
  parameter int         FIFO_DEPTH      = 4,
  parameter int         LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  gbus_core_rx_if.slave              bus,
  input  logic                       cfg_start,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  input  logic                       core_sram_busy,
  output logic                       sram_wen,
  output logic [1:0]                 sram_bank,
  output logic [12:0]                sram_addr,
  output logic [GBUS_DATA_WIDTH-1:0] sram_wdata,
  output logic                       rx_busy,
  output logic                       rx_done,
  output logic                       fifo_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = GBUS_DATA_WIDTH;

  typedef struct packed {
    logic [1:0]    bank;
    logic [12:0]   addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // stage 1: bus capture
  logic s1_hit;
  ent_t s1_ent;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_hit <= 1'b0;
      s1_ent <= '0;
    end else begin
      s1_hit <= bus.gbus_wen &&
                (bus.gbus_addr[16:13] == CORE_INDEX);
      s1_ent <= '{bank: bus.gbus_addr[18:17],
                  addr: bus.gbus_addr[12:0],
                  data: bus.gbus_wdata};
    end
  end

  // stage 2: receive FIFO
  ent_t         mem [FIFO_DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         full;
  logic         empty;
  logic         pop;
  logic         push;
  ent_t         head;

  // pointers carry one extra wrap bit to tell full from empty
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = !empty && !core_sram_busy;
  // a pop in the same cycle frees the slot the push needs
  assign push  = s1_hit && (!full || pop);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp[AW-1:0]] <= s1_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wp       <= '0;
      rp       <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      if (s1_hit && !push) begin
        fifo_ovf <= 1'b1;
      end
    end
  end

  // drain into SRAM port
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sram_wen   <= 1'b0;
      sram_bank  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_wen <= pop;
      if (pop) begin
        sram_bank  <= head.bank;
        sram_addr  <= head.addr;
        sram_wdata <= head.data;
      end
    end
  end

  // transfer tracking
  state_t               state_q;
  state_t               state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 load;

  assign cnt_inc = cnt_q + LEN_WIDTH'(1);
  assign load    = cfg_start && (state_q != DONE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_len == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        // restart wins; that cycle's write is not counted
        if (cfg_start) begin
          state_d = (cfg_len == '0) ? DONE : RECV;
        end else if (pop && (cnt_inc == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rx_busy = 1'b0;
    rx_done = 1'b0;
    unique case (state_q)
      RECV:    rx_busy = 1'b1;
      DONE:    rx_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      len_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      len_q <= cfg_len;
      cnt_q <= '0;
    end else if ((state_q == RECV) && pop) begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_gbus_core_rx.sv
// Self-checking bench for gbus_core_rx: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_gbus_core_rx;

  localparam int         DW    = 32;
  localparam int         DEPTH = 4;
  localparam int         LW    = 16;
  localparam logic [3:0] IDX   = 4'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy = 1'b0;
  logic          sram_wen;
  logic [1:0]    sram_bank;
  logic [12:0]   sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          rx_busy;
  logic          rx_done;
  logic          fifo_ovf;

  always #5 clk = ~clk;

  gbus_core_rx_if #(.DW(DW)) bus ();

  gbus_core_rx #(
    .CORE_INDEX     (IDX),
    .GBUS_DATA_WIDTH(DW),
    .FIFO_DEPTH     (DEPTH),
    .LEN_WIDTH      (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .cfg_start     (cfg_start),
    .cfg_len       (cfg_len),
    .core_sram_busy(busy),
    .sram_wen      (sram_wen),
    .sram_bank     (sram_bank),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .rx_busy       (rx_busy),
    .rx_done       (rx_done),
    .fifo_ovf      (fifo_ovf)
  );

  typedef struct packed {
    logic [1:0]    bank;
    logic [12:0]   addr;
    logic [DW-1:0] data;
  } word_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [31:0] seen[$];
  int          wcyc[$];

  // reference model state
  word_t         m_q[$];
  logic          m_s1_hit = 1'b0;
  word_t         m_s1 = '0;
  logic          m_wen = 1'b0;
  word_t         m_out = '0;
  logic          m_ovf = 1'b0;
  int            m_state = 0;
  int            m_len = 0;
  int            m_cnt = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // one clock edge of the model, driven by the inputs sampled at it
  task automatic model_step();
    logic  pop;
    int    old;
    word_t e;
    if (rst_n) begin
      m_q.delete();
      m_s1_hit = 1'b0;
      m_s1 = '0;
      m_wen = 1'b0;
      m_out = '0;
      m_ovf = 1'b0;
      m_state = 0;
      m_len = 0;
      m_cnt = 0;
      return;
    end
    pop = (m_q.size() != 0) && !busy;
    m_wen = pop;
    if (pop) begin
      e = m_q.pop_front();
      m_out = e;
    end
    if (m_s1_hit) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_s1);
      else m_ovf = 1'b1;
    end
    m_s1_hit = bus.gbus_wen && (bus.gbus_addr[16:13] == IDX);
    m_s1 = '{bank: bus.gbus_addr[18:17],
             addr: bus.gbus_addr[12:0],
             data: bus.gbus_wdata};
    old = m_state;
    if (old == 2) begin
      m_state = 0;
    end else if (cfg_start) begin
      m_len = int'(cfg_len);
      m_cnt = 0;
      m_state = (m_len == 0) ? 2 : 1;
    end else if (old == 1 && pop) begin
      m_cnt++;
      if (m_cnt == m_len) m_state = 2;
    end
  endtask

  task automatic compare();
    chk("sram_wen", sram_wen, m_wen);
    chk("sram_bank", sram_bank, m_out.bank);
    chk("sram_addr", sram_addr, m_out.addr);
    chk("sram_wdata", sram_wdata, m_out.data);
    chk("rx_busy", rx_busy, m_state == 1);
    chk("rx_done", rx_done, m_state == 2);
    chk("fifo_ovf", fifo_ovf, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    model_step();
    compare();
    if (sram_wen === 1'b1) begin
      seen.push_back(sram_wdata);
      wcyc.push_back(cyc);
    end
    if (rx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    bus.gbus_wen = 1'b0;
    cfg_start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic start(int l);
    cfg_start = 1'b1;
    cfg_len = LW'(l);
    tick();
  endtask

  task automatic word(logic [3:0] c, logic [1:0] b,
                      logic [12:0] a, logic [31:0] d);
    bus.gbus_wen = 1'b1;
    bus.gbus_addr = {b, c, a};
    bus.gbus_wdata = d;
    tick();
  endtask

  task automatic clr();
    seen.delete();
    wcyc.delete();
  endtask

  initial begin
    int d0;
    logic [3:0] others[8] = '{4'd0, 4'd1, 4'd2, 4'd4,
                              4'd5, 4'd6, 4'd7, 4'd0};
    bus.gbus_wen = 1'b0;
    bus.gbus_addr = '0;
    bus.gbus_wdata = '0;
    idle(2);
    rst_n = 1'b0;
    chk("rst_wen", sram_wen, 1'b0);
    chk("rst_wdata", sram_wdata, 32'h0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_ovf", fifo_ovf, 1'b0);

    // basic hit
    start(1);
    clr();
    word(IDX, 2'd1, 13'h0A5, 32'hDEADBEEF);
    idle(1);
    chk("basic_early", seen.size(), 0);
    idle(1);
    chk("basic_wen", sram_wen, 1'b1);
    chk("basic_bank", sram_bank, 2'd1);
    chk("basic_addr", sram_addr, 13'h0A5);
    chk("basic_wdata", sram_wdata, 32'hDEADBEEF);
    chk("basic_done", rx_done, 1'b1);
    idle(1);
    chk("basic_idle", {rx_busy, rx_done}, 2'b00);

    // filtering
    start(5);
    clr();
    for (int i = 0; i < 8; i++)
      word(others[i], 2'd0, 13'(i), 32'(i));
    idle(3);
    chk("filt_writes", seen.size(), 0);
    chk("filt_busy", rx_busy, 1'b1);

    // stall and ordering (restart from RECV)
    busy = 1'b1;
    start(4);
    clr();
    d0 = done_cnt;
    for (int i = 1; i <= 4; i++) word(IDX, 2'd0, 13'(i), 32'(i));
    idle(3);
    chk("stall_none", seen.size(), 0);
    busy = 1'b0;
    idle(6);
    chk("stall_n", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("stall_data", seen[i], 32'(i + 1));
    chk("stall_b2b", wcyc[3] - wcyc[0], 3);
    chk("stall_ovf", fifo_ovf, 1'b0);
    chk("stall_done", done_cnt - d0, 1);

    // overflow
    busy = 1'b1;
    start(4);
    clr();
    for (int i = 1; i <= 5; i++) word(IDX, 2'd2, 13'(i), 32'(i));
    chk("ovf_before", fifo_ovf, 1'b0);
    idle(1);
    chk("ovf_set", fifo_ovf, 1'b1);
    busy = 1'b0;
    idle(8);
    chk("ovf_n", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("ovf_data", seen[i], 32'(i + 1));
    chk("ovf_sticky", fifo_ovf, 1'b1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("ovf_clr", fifo_ovf, 1'b0);

    // full FIFO with simultaneous pop
    busy = 1'b1;
    start(5);
    clr();
    d0 = done_cnt;
    for (int i = 11; i <= 15; i++) word(IDX, 2'd3, 13'(i), 32'(i));
    busy = 1'b0;
    idle(8);
    chk("full_ovf", fifo_ovf, 1'b0);
    chk("full_n", seen.size(), 5);
    for (int i = 0; i < 5; i++) chk("full_data", seen[i], 32'(i + 11));
    chk("full_done", done_cnt - d0, 1);

    // restart mid-transfer
    start(3);
    clr();
    d0 = done_cnt;
    word(IDX, 2'd0, 13'h21, 32'h21);
    word(IDX, 2'd0, 13'h22, 32'h22);
    idle(3);
    chk("rs_first", seen.size(), 2);
    start(2);
    word(IDX, 2'd0, 13'h23, 32'h23);
    word(IDX, 2'd0, 13'h24, 32'h24);
    idle(4);
    chk("rs_n", seen.size(), 4);
    chk("rs_done", done_cnt - d0, 1);
    chk("rs_when", done_cyc, wcyc[3]);

    // reset mid-transfer with buffered words
    busy = 1'b1;
    start(5);
    word(IDX, 2'd1, 13'h31, 32'h31);
    word(IDX, 2'd1, 13'h32, 32'h32);
    idle(2);
    rst_n = 1'b1;
    busy = 1'b0;
    tick();
    rst_n = 1'b0;
    clr();
    d0 = done_cnt;
    idle(6);
    chk("mr_writes", seen.size(), 0);
    chk("mr_done", done_cnt - d0, 0);
    chk("mr_outs", {sram_wen, sram_bank, sram_addr, sram_wdata,
                    rx_busy, rx_done, fifo_ovf}, '0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.gbus_wen = 1'($urandom_range(0, 1));
      bus.gbus_addr = {2'($urandom_range(0, 3)),
                       ($urandom_range(0, 2) == 0) ?
                         4'($urandom_range(0, 15)) : IDX,
                       13'($urandom)};
      bus.gbus_wdata = $urandom;
      busy = ($urandom_range(0, 3) == 0);
      cfg_start = ($urandom_range(0, 40) == 0);
      cfg_len = LW'($urandom_range(0, 6));
      rst_n = ($urandom_range(0, 500) == 0);
      tick();
    end
    rst_n = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
